eth_tx_frame_ctrl: RTL and testbench
====================================

// Module: eth_tx_frame_ctrl
// PURPOSE
//  MAC transmit sequencer between the byte-wide TX FIFO and the PHY-side GMII-style byte interface.
//  On a host start command, emits preamble and SFD, then tx_len payload bytes read from the FIFO.
//  Appends zero padding up to the minimum frame size, then the CRC-32 FCS, then enforces the inter-frame gap.
//  Aborts the frame with tx_er if the FIFO underruns.
// PARAMETERS
//  LEN_WIDTH    11  width of tx_len
//  PREAMBLE_LEN  7  number of 0x55 preamble bytes before the SFD
//  MIN_DATA     60  minimum data+pad bytes per frame, excluding FCS
//  IFG_CYCLES   12  idle cycles after each frame, completed or aborted
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  rst_n        in   1          reset, asynchronous, active-low
//  tx_start     in   1          start request, sampled only in IDLE
//  tx_len       in   LEN_WIDTH  payload byte count, sampled with tx_start
//  tx_busy      out  1          controller not in IDLE
//  tx_done      out  1          1-cycle pulse: frame fully sent
//  tx_underrun  out  1          1-cycle pulse: frame aborted on FIFO empty
//  fifo_rd_en   out  1          FIFO read strobe
//  fifo_data    in   8          FIFO read data, valid the cycle after fifo_rd_en
//  fifo_empty   in   1          FIFO empty flag
//  txd          out  8          transmit byte
//  tx_en        out  1          txd carries a frame byte
//  tx_er        out  1          transmit error, marks the abort byte
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, CRC = 0xFFFFFFFF.
//  - Takes effect immediately mid-frame: tx_en drops, and no tx_done or tx_underrun pulse is produced.
//  Outputs txd, tx_en, tx_er, tx_done and tx_underrun are registered. fifo_rd_en is combinational from state and counters.
//  FSM states: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
//  - PAD is skipped when tx_len >= MIN_DATA.
//  - An underrun takes DATA -> ABORT -> IFG.
//  IDLE transition:
//  - tx_start=1 with tx_len!=0 in cycle T: PRE; tx_en=1, txd=0x55 from cycle T+1.
//  - tx_start with tx_len=0 is ignored.
//  - tx_start outside IDLE is ignored.
//  PRE/SFD: PREAMBLE_LEN bytes of 0x55, then one byte 0xD5.
//  DATA: payload bytes on txd in FIFO order, tx_len bytes.
//  - A byte read with fifo_rd_en in cycle k appears on txd in cycle k+2.
//  - Reads occur in tx_len consecutive cycles, the first being the cycle showing the last preamble byte.
//  - fifo_rd_en is never asserted while fifo_empty=1 and is never asserted outside these tx_len cycles.
//  Underrun: a read is due while fifo_empty=1.
//  - No read is issued.
//  - In the cycle that byte would have appeared: txd=0x00, tx_en=1, tx_er=1, tx_underrun=1.
//  - Then tx_en=0 and IFG; no tx_done pulse.
//  PAD: 0x00 bytes until data+pad = MIN_DATA.
//  CRC:
//  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF.
//  - Covers payload and pad only, not preamble/SFD.
//  - The 8-bit/cycle update is a function of the current CRC and the byte being driven on txd.
//  FCS: 4 bytes of ~CRC, least-significant byte first.
//  Timing totals:
//  - tx_en high for PREAMBLE_LEN + 1 + max(tx_len, MIN_DATA) + 4 cycles.
//  - tx_done pulses in the first cycle with tx_en=0, the first IFG cycle.
//  IFG: tx_en=0, txd=0x00 for IFG_CYCLES cycles.
//  - tx_busy falls in the cycle after the last IFG cycle; tx_start is accepted from then on.
//  tx_busy: high from cycle T+1 through the end of IFG.
//  tx_er: 0 in all cycles except the abort byte.
// TESTING
//  - 64-byte frame: FIFO preloaded with 0x00..0x3F, tx_len=64.
//    -> txd shows 7x0x55, 0xD5, 0x00..0x3F, then 4 FCS bytes; tx_en high 76 cycles.
//    -> tx_done pulses, then tx_busy low after 12 idle cycles.
//  - Pad: tx_len=1 with FIFO holding 0xAB.
//    -> 0xAB followed by 59x0x00, then FCS; tx_en high 72 cycles; fifo_rd_en high exactly 1 cycle.
//  - CRC: random 100-byte payload.
//    -> Running the same CRC over payload+FCS as received on txd gives residue 0xDEBB20E3 (~0x2144DF1C, the standard non-complemented residue).
//  - Underrun: FIFO holding 10 bytes, tx_len=20.
//    -> 10 data bytes, then one cycle of tx_er=1 with tx_underrun=1, then tx_en=0.
//    -> No tx_done; IFG of 12 cycles.
//  - Ignore cases: tx_start with tx_len=0 -> no activity; tx_start during DATA -> ignored, current frame intact.
//  - Reset mid-DATA: rst_n low -> txd, tx_en, tx_busy and fifo_rd_en all 0.
//    -> After release, a new tx_start sends a correct frame.

Source files
------------

// File: rtl/eth_tx_frame_ctrl.sv
// MAC transmit sequencer: preamble/SFD, FIFO payload, zero pad, CRC-32 FCS, inter-frame gap.
// Aborts with tx_er on FIFO underrun. Byte outputs are registered; fifo_rd_en is combinational.
module eth_tx_frame_ctrl #(
    parameter int LEN_WIDTH    = 11,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA     = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [LEN_WIDTH-1:0] tx_len,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_underrun,
    output logic                 fifo_rd_en,
    input  logic [7:0]           fifo_data,
    input  logic                 fifo_empty,
    output logic [7:0]           txd,
    output logic                 tx_en,
    output logic                 tx_er
);

    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [31:0]          crc, crc_d, crc_next, fcs_word;
    logic                 uflag, uflag_d;
    logic                 rd_due, underrun_now;
    logic [7:0]           txd_d;
    logic                 en_d, er_d, done_d, und_d;
    logic [CW-1:0]        len_ext;

    function automatic logic [31:0] crc8_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign len_ext  = {1'b0, len_q};
    assign crc_next = crc8_update(crc, txd);
    assign fcs_word = ~crc;
    assign tx_busy  = (state != S_IDLE);

    // Read i is issued two cycles before byte i is shown: last preamble cycle, SFD, then DATA.
    always_comb begin
        rd_due = 1'b0;
        case (state)
            S_PRE:   rd_due = (cnt == CW'(PREAMBLE_LEN - 1));
            S_SFD:   rd_due = (len_ext > CW'(1));
            S_DATA:  rd_due = ((cnt + CW'(2)) < len_ext);
            default: rd_due = 1'b0;
        endcase
        rd_due = rd_due & ~uflag;
    end

    assign fifo_rd_en   = rd_due & ~fifo_empty;
    assign underrun_now = rd_due & fifo_empty;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        len_d   = len_q;
        crc_d   = crc;
        uflag_d = uflag | underrun_now;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        und_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_start && (tx_len != '0)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    len_d   = tx_len;
                    crc_d   = 32'hFFFF_FFFF;
                    uflag_d = 1'b0;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                end
            end
            S_PRE: begin
                en_d = 1'b1;
                if (cnt == CW'(PREAMBLE_LEN - 1)) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                    txd_d   = 8'hD5;
                end else begin
                    cnt_d = cnt + CW'(1);
                    txd_d = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                en_d = 1'b1;
                if (state == S_DATA)
                    crc_d = crc_next;
                if (uflag) begin
                    // The byte due next was never read: mark it as the abort byte.
                    state_d = S_ABORT;
                    er_d    = 1'b1;
                    und_d   = 1'b1;
                end else if (state == S_SFD) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    txd_d   = fifo_data;
                end else if (cnt == len_ext - CW'(1)) begin
                    if (len_ext >= CW'(MIN_DATA)) begin
                        state_d = S_FCS;
                        cnt_d   = '0;
                        txd_d   = ~crc_next[7:0];
                    end else begin
                        state_d = S_PAD;
                        cnt_d   = cnt + CW'(1);
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                    txd_d = fifo_data;
                end
            end
            S_PAD: begin
                en_d  = 1'b1;
                crc_d = crc_next;
                if (cnt == CW'(MIN_DATA - 1)) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                    txd_d   = ~crc_next[7:0];
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_FCS: begin
                if (cnt == CW'(3)) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt + CW'(1);
                    case (cnt[1:0])
                        2'd0:    txd_d = fcs_word[15:8];
                        2'd1:    txd_d = fcs_word[23:16];
                        default: txd_d = fcs_word[31:24];
                    endcase
                end
            end
            S_ABORT: begin
                state_d = S_IFG;
                cnt_d   = '0;
            end
            S_IFG: begin
                if (cnt == CW'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            len_q       <= '0;
            crc         <= 32'hFFFF_FFFF;
            uflag       <= 1'b0;
            txd         <= 8'h00;
            tx_en       <= 1'b0;
            tx_er       <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            len_q       <= len_d;
            crc         <= crc_d;
            uflag       <= uflag_d;
            txd         <= txd_d;
            tx_en       <= en_d;
            tx_er       <= er_d;
            tx_done     <= done_d;
            tx_underrun <= und_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Directed bench for eth_tx_frame_ctrl: FIFO model, negedge byte monitor and reference CRC-32.
// Expected frames are rebuilt from the payload the bench loaded.
module tb_eth_tx_frame_ctrl;

    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_start = 1'b0;
    logic [LW-1:0] tx_len = '0;
    logic          tx_busy, tx_done, tx_underrun, fifo_rd_en;
    logic [7:0]    fifo_data = 8'h00;
    logic          fifo_empty;
    logic [7:0]    txd;
    logic          tx_en, tx_er;

    eth_tx_frame_ctrl #(.LEN_WIDTH(LW), .PREAMBLE_LEN(7), .MIN_DATA(60), .IFG_CYCLES(12)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_len(tx_len),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .txd(txd), .tx_en(tx_en), .tx_er(tx_er)
    );

    always #5 clk = ~clk;

    // FIFO model: bench pushes, the clocked process pops one cycle ahead of the data.
    logic [7:0] fifo_mem [256];
    int push_cnt = 0;
    int pop_cnt  = 0;
    int rd_n     = 0;
    int rd_empty = 0;
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) rd_n <= rd_n + 1;
        if (fifo_rd_en && fifo_empty) rd_empty <= rd_empty + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fifo_mem[pop_cnt % 256];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // Line monitor, all counters monotonic.
    logic [7:0] cap [2048];
    int   cap_n = 0, done_n = 0, done_ok = 0, und_n = 0, er_n = 0, abort_ok = 0, idle_busy = 0;
    logic prev_en = 1'b0;

    always @(negedge clk) begin
        if (tx_en) begin
            cap[cap_n % 2048] <= txd;
            cap_n <= cap_n + 1;
        end
        if (tx_done) done_n <= done_n + 1;
        if (tx_done && prev_en && !tx_en) done_ok <= done_ok + 1;
        if (tx_underrun) und_n <= und_n + 1;
        if (tx_er) er_n <= er_n + 1;
        if (tx_er && tx_underrun && tx_en && txd == 8'h00) abort_ok <= abort_ok + 1;
        if (tx_busy && !tx_en) idle_busy <= idle_busy + 1;
        prev_en <= tx_en;
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] pay [256];
    logic [7:0] expv [256];
    int exp_n;
    int s_cap, s_done, s_dok, s_und, s_er, s_abort, s_idle, s_rd;

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_chk++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [7:0] b);
        pay[idx] = b;
        fifo_mem[push_cnt % 256] = b;
        push_cnt++;
    endtask

    task automatic snap();
        s_cap = cap_n; s_done = done_n; s_dok = done_ok; s_und = und_n;
        s_er = er_n; s_abort = abort_ok; s_idle = idle_busy; s_rd = rd_n;
    endtask

    task automatic send(input int len);
        tick();
        snap();
        tx_start = 1'b1;
        tx_len   = LW'(len);
        tick();
        tx_start = 1'b0;
        chk("start_busy", tx_busy, 1);
        chk("start_txd", {tx_en, txd}, {1'b1, 8'h55});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (!tx_busy) break;
            tick();
        end
        chk("idle_timeout", tx_busy, 0);
    endtask

    task automatic build_normal(input int len);
        logic [31:0] c;
        int n;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) expv[i] = 8'h55;
        expv[7] = 8'hD5;
        n = (len < 60) ? 60 : len;
        for (int i = 0; i < n; i++) begin
            expv[8 + i] = (i < len) ? pay[i] : 8'h00;
            c = ref_crc(c, expv[8 + i]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) expv[8 + n + i] = c[8*i +: 8];
        exp_n = 8 + n + 4;
    endtask

    task automatic cmp_bytes(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_n; i++)
            if (cap[(s_cap + i) % 2048] !== expv[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic check_normal(input int len);
        build_normal(len);
        chk("en_cycles", cap_n - s_cap, exp_n);
        cmp_bytes("frame_bytes");
        chk("done_pulse", done_n - s_done, 1);
        chk("done_first_idle", done_ok - s_dok, 1);
        chk("no_underrun", und_n - s_und, 0);
        chk("no_er", er_n - s_er, 0);
        chk("ifg_cycles", idle_busy - s_idle, 12);
        chk("rd_cycles", rd_n - s_rd, len);
    endtask

    initial begin
        logic [31:0] res;

        // Reset state
        tick();
        chk("rst_outputs", {txd, tx_en, tx_er, tx_done, tx_underrun, tx_busy, fifo_rd_en}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", tx_busy, 0);

        // tx_start with zero length is ignored
        snap();
        tx_start = 1'b1;
        tx_len   = '0;
        tick();
        tx_start = 1'b0;
        tick();
        chk("len0_busy", tx_busy, 0);
        chk("len0_en", tx_en, 0);
        chk("len0_rd", rd_n - s_rd, 0);

        // 64-byte frame, payload 0x00..0x3F
        for (int i = 0; i < 64; i++) push(i, 8'(i));
        send(64);
        wait_idle();
        check_normal(64);

        // Short frame padded to minimum
        push(0, 8'hAB);
        send(1);
        wait_idle();
        check_normal(1);

        // 100-byte random payload, stray tx_start mid-DATA
        for (int i = 0; i < 100; i++) push(i, 8'($urandom_range(0, 255)));
        send(100);
        repeat (30) tick();
        tx_start = 1'b1;
        tx_len   = LW'(5);
        tick();
        tx_start = 1'b0;
        wait_idle();
        check_normal(100);
        res = 32'hFFFF_FFFF;
        for (int i = 0; i < 104; i++) res = ref_crc(res, cap[(s_cap + 8 + i) % 2048]);
        chk("crc_residue", res, 32'hDEBB_20E3);
        repeat (3) tick();
        chk("stray_start_ignored", tx_busy, 0);

        // Underrun: 10 bytes available, 20 requested
        for (int i = 0; i < 10; i++) push(i, 8'hA0 + 8'(i));
        send(20);
        wait_idle();
        for (int i = 0; i < 7; i++) expv[i] = 8'h55;
        expv[7] = 8'hD5;
        for (int i = 0; i < 10; i++) expv[8 + i] = pay[i];
        expv[18] = 8'h00;
        exp_n = 19;
        chk("ur_en_cycles", cap_n - s_cap, 19);
        cmp_bytes("ur_bytes");
        chk("ur_pulse", und_n - s_und, 1);
        chk("ur_er_cycles", er_n - s_er, 1);
        chk("ur_abort_byte", abort_ok - s_abort, 1);
        chk("ur_no_done", done_n - s_done, 0);
        chk("ur_ifg", idle_busy - s_idle, 12);
        chk("ur_rd", rd_n - s_rd, 10);

        // Reset in the middle of DATA
        for (int i = 0; i < 30; i++) push(i, 8'h30 + 8'(i));
        send(30);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {txd, tx_en, tx_busy, fifo_rd_en}, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", done_n - s_done, 0);
        chk("midrst_no_und", und_n - s_und, 0);
        push_cnt = pop_cnt;
        for (int i = 0; i < 3; i++) push(i, 8'hC0 + 8'(i));
        send(3);
        wait_idle();
        check_normal(3);

        chk("rd_while_empty", rd_empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
